// File: rtl/imem_pkg.sv
// imem_pkg: shared constants for the instruction-memory boot loader.
//   - loader state encodings (IDLE, HDR0, HDR1, DATA, CSUM, DONE)
//   - stream framing sizes: header bytes and bytes per word
package imem_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR0 = 3'd1;
  localparam logic [2:0] ST_HDR1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// byte_to_word: little-endian byte-to-word assembler.
// The first byte of a word lands in bits [7:0]. word_valid is a
// combinational pulse in the cycle the fourth byte is shifted in, with
// word already holding the complete value (the incoming byte on top).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clr         drop any partial word (start of a new load)
//   shift       accept data this cycle
//   data        incoming byte
//   word_valid  fourth byte of a word is being accepted
//   word        assembled 32-bit word
module byte_to_word
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  assign word_valid = shift && (cnt == 2'(WORD_BYTES - 1));
  assign word       = {data, sr};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {data, sr[23:8]};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a length-prefixed byte stream, assembles little-endian words
// and writes them to consecutive word addresses, holding the core in
// reset until a complete valid image is loaded.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over header and payload.
// Ports:
//   iclk, irst            clock, synchronous active-high reset
//   istart                start a load (only from IDLE or DONE)
//   ibyte_valid, ibyte    byte stream in
//   obyte_ready           byte accepted when ibyte_valid && obyte_ready
//   owe, oaddr, owdata    one-cycle word write to the instruction RAM
//   obusy, odone, oerr    load status
//   ocpu_rst              core reset request
//
// state | meaning
// IDLE  | after reset, waiting for istart
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte
// DATA  | receiving payload words
// CSUM  | waiting for checksum byte (checksum build only)
// DONE  | load finished, status held until next istart
module imem_loader
  import imem_pkg::*;
#(
  parameter int MP_WIDTH = 32,
  parameter int MP_DEPTH = 256
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                istart,
  input  logic                ibyte_valid,
  input  logic [7:0]          ibyte,
  output logic                obyte_ready,
  output logic                owe,
  output logic [MP_WIDTH-1:0] oaddr,
  output logic [MP_WIDTH-1:0] owdata,
  output logic                obusy,
  output logic                odone,
  output logic                oerr,
  output logic                ocpu_rst
);

  localparam int CW = $clog2(MP_DEPTH + 1);

  logic [2:0]    state;
  logic [15:0]   len;
  logic [CW-1:0] word_idx;
  logic          take;
  logic          start_ok;
  logic          word_valid;
  logic [31:0]   word;
  logic [15:0]   n_full;
  logic          last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign obyte_ready = (state == ST_HDR0) || (state == ST_HDR1) ||
                       (state == ST_DATA) || (state == ST_CSUM);
  assign take        = ibyte_valid && obyte_ready;
  assign start_ok    = istart && ((state == ST_IDLE) || (state == ST_DONE));
  assign n_full      = {ibyte, len[7:0]};
  assign last_word   = (16'(word_idx) + 16'd1) == len;

  byte_to_word u_b2w (
    .clk        (iclk),
    .rst        (irst),
    .clr        (start_ok),
    .shift      (take && (state == ST_DATA)),
    .data       (ibyte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state    <= ST_IDLE;
      len      <= '0;
      word_idx <= '0;
      owe      <= 1'b0;
      oaddr    <= '0;
      owdata   <= '0;
      obusy    <= 1'b0;
      odone    <= 1'b0;
      oerr     <= 1'b0;
      ocpu_rst <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      owe <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (take && (state != ST_CSUM))
        csum <= csum ^ ibyte;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          if (istart) begin
            state    <= ST_HDR0;
            len      <= '0;
            word_idx <= '0;
            obusy    <= 1'b1;
            odone    <= 1'b0;
            oerr     <= 1'b0;
            ocpu_rst <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        ST_HDR0: begin
          if (take) begin
            len[7:0] <= ibyte;
            state    <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (take) begin
            len[15:8] <= ibyte;
            if (n_full > 16'(MP_DEPTH)) begin
              // oversize image: refuse before any write reaches memory
              state    <= ST_DONE;
              obusy    <= 1'b0;
              odone    <= 1'b1;
              oerr     <= 1'b1;
              ocpu_rst <= 1'b1;
            end else if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= ST_CSUM;
`else
              state    <= ST_DONE;
              obusy    <= 1'b0;
              odone    <= 1'b1;
              oerr     <= 1'b0;
              ocpu_rst <= 1'b0;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            owe      <= 1'b1;
            owdata   <= MP_WIDTH'(word);
            oaddr    <= MP_WIDTH'({word_idx, 2'b00});
            word_idx <= word_idx + 1'b1;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= ST_CSUM;
`else
              state    <= ST_DONE;
              obusy    <= 1'b0;
              odone    <= 1'b1;
              oerr     <= 1'b0;
              ocpu_rst <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (take) begin
            state    <= ST_DONE;
            obusy    <= 1'b0;
            odone    <= 1'b1;
            oerr     <= (ibyte != csum);
            ocpu_rst <= (ibyte != csum);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// Builds random images, serialises them into the framed byte stream,
// drives the stream with optional random valid gaps and compares the
// observed memory writes and final status against the image itself.
// Honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DEPTH = 256;

  logic        iclk = 1'b0;
  logic        irst;
  logic        istart;
  logic        ibyte_valid;
  logic [7:0]  ibyte;
  logic        obyte_ready;
  logic        owe;
  logic [31:0] oaddr;
  logic [31:0] owdata;
  logic        obusy;
  logic        odone;
  logic        oerr;
  logic        ocpu_rst;

  imem_loader #(.MP_WIDTH(32), .MP_DEPTH(DEPTH)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .istart      (istart),
    .ibyte_valid (ibyte_valid),
    .ibyte       (ibyte),
    .obyte_ready (obyte_ready),
    .owe         (owe),
    .oaddr       (oaddr),
    .owdata      (owdata),
    .obusy       (obusy),
    .odone       (odone),
    .oerr        (oerr),
    .ocpu_rst    (ocpu_rst)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  logic [31:0] img[$];
  logic [7:0]  stream[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          accepted;
  int          stalls;
  int          owe_consec;
  logic        prev_owe = 1'b0;
  logic        done_at_last_owe;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  always @(negedge iclk) begin
    if (owe) begin
      wq_addr.push_back(oaddr);
      wq_data.push_back(owdata);
      done_at_last_owe = odone;
      if (prev_owe) owe_consec++;
    end
    prev_owe = owe;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic pulse_start();
    istart = 1'b1;
    tick();
    istart = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and waits (bounded) until taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit count_stall);
    int n;
    repeat (gap) begin
      ibyte_valid = 1'b0;
      ibyte = 8'($urandom);
      tick();
    end
    ibyte_valid = 1'b1;
    ibyte = b;
    n = 0;
    while (!obyte_ready && n < 50) begin
      tick();
      n++;
    end
    if (count_stall) stalls += n;
    if (obyte_ready) begin
      tick();
      accepted++;
    end
    ibyte_valid = 1'b0;
  endtask

  task automatic fill_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // Serialise header N, the image words (LSB first) and, if enabled, the checksum.
  task automatic load(input int n, input int gapmax, input bit bad_csum, input bit mid_start);
    logic [7:0] x;
    ibyte_valid = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    accepted = 0;
    stalls = 0;
    owe_consec = 0;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++)
        for (int b = 0; b < WORD_BYTES; b++) stream.push_back(img[i][8*b +: 8]);
      if (CSUM_ON) begin
        x = 8'h00;
        foreach (stream[k]) x ^= stream[k];
        stream.push_back(bad_csum ? ~x : x);
      end
    end
    pulse_start();
    foreach (stream[k]) begin
      if (mid_start && k == 6) istart = 1'b1;
      send_byte(stream[k], (gapmax == 0) ? 0 : $urandom_range(gapmax, 0), k >= HDR_BYTES);
      istart = 1'b0;
    end
    for (int i = 0; i < 100 && !odone; i++) tick();
    tick();
  endtask

  task automatic check_load(input string tag, input int n, input bit exp_err);
    int exp_n;
    exp_n = (n <= DEPTH) ? n : 0;
    chk({tag, "_writes"}, 32'(wq_addr.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wq_addr.size(); i++) begin
      chk({tag, "_addr"}, wq_addr[i], 32'(i * 4));
      chk({tag, "_data"}, wq_data[i], img[i]);
    end
    chk({tag, "_done"}, 32'(odone), 32'd1);
    chk({tag, "_busy"}, 32'(obusy), 32'd0);
    chk({tag, "_err"}, 32'(oerr), 32'(exp_err));
    chk({tag, "_cpu_rst"}, 32'(ocpu_rst), 32'(exp_err));
    chk({tag, "_ready"}, 32'(obyte_ready), 32'd0);
    chk({tag, "_owe_width"}, 32'(owe_consec), 32'd0);
    chk({tag, "_bytes"}, 32'(accepted), 32'(stream.size()));
    if (exp_n > 0) begin
      chk({tag, "_addr_hold"}, oaddr, 32'((exp_n - 1) * 4));
      chk({tag, "_done_with_last_owe"}, 32'(done_at_last_owe), 32'(!CSUM_ON));
    end
  endtask

  initial begin
    irst = 1'b1;
    istart = 1'b0;
    ibyte_valid = 1'b0;
    ibyte = 8'h00;
    repeat (3) tick();
    chk("rst_ready", 32'(obyte_ready), 32'd0);
    chk("rst_owe", 32'(owe), 32'd0);
    chk("rst_oaddr", oaddr, 32'd0);
    chk("rst_owdata", owdata, 32'd0);
    chk("rst_busy", 32'(obusy), 32'd0);
    chk("rst_done", 32'(odone), 32'd0);
    chk("rst_err", 32'(oerr), 32'd0);
    chk("rst_cpu_rst", 32'(ocpu_rst), 32'd1);
    irst = 1'b0;
    tick();

    // single known word
    img.delete();
    img.push_back(32'h00A00513);
    load(1, 0, 1'b0, 1'b0);
    check_load("single", 1, 1'b0);

    // three words back to back, valid every cycle
    fill_img(3);
    load(3, 0, 1'b0, 1'b0);
    check_load("b2b", 3, 1'b0);
    chk("b2b_stalls", 32'(stalls), 32'd0);
    chk("b2b_accepted", 32'(accepted), 32'(HDR_BYTES + 12 + (CSUM_ON ? 1 : 0)));

    // random lengths with random gaps
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(8, 1);
      fill_img(n);
      load(n, 5, 1'b0, 1'b0);
      check_load("gaps", n, 1'b0);
    end

    // oversize and empty images
    load(DEPTH + 1, 0, 1'b0, 1'b0);
    check_load("oversize", DEPTH + 1, 1'b1);
    img.delete();
    load(0, 2, 1'b0, 1'b0);
    check_load("empty", 0, 1'b0);

    // largest legal image
    fill_img(DEPTH);
    load(DEPTH, 0, 1'b0, 1'b0);
    check_load("full", DEPTH, 1'b0);

    // istart during DATA is ignored
    fill_img(3);
    load(3, 1, 1'b0, 1'b1);
    check_load("mid_start", 3, 1'b0);

    // reset after two payload bytes
    wq_addr.delete();
    wq_data.delete();
    accepted = 0;
    pulse_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    irst = 1'b1;
    tick();
    irst = 1'b0;
    chk("rst_mid_cpu_rst", 32'(ocpu_rst), 32'd1);
    chk("rst_mid_busy", 32'(obusy), 32'd0);
    chk("rst_mid_ready", 32'(obyte_ready), 32'd0);
    ibyte_valid = 1'b1;
    ibyte = 8'h33;
    repeat (3) tick();
    ibyte_valid = 1'b0;
    chk("rst_mid_no_owe", 32'(wq_addr.size()), 32'd0);
    chk("rst_mid_ready_idle", 32'(obyte_ready), 32'd0);
    fill_img(2);
    load(2, 0, 1'b0, 1'b0);
    check_load("after_rst", 2, 1'b0);

    if (CSUM_ON) begin
      img.delete();
      img.push_back(32'h00A00513);
      load(1, 0, 1'b0, 1'b0);
      chk("csum_byte", 32'(stream[stream.size()-1]), 32'hB7);
      check_load("csum_ok", 1, 1'b0);
      load(1, 0, 1'b1, 1'b0);
      check_load("csum_bad", 1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
